// File: rtl/tdm_demux_4.sv
// 4-channel TDM receive demultiplexer: steers a framed serial stream into four channel words.
// Optional sync-loss detection is enabled by defining TDM_DEMUX_LOSS_EN.
module tdm_demux_4 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               din,
   input  logic               fsync,
   output logic [4*WIDTH-1:0] dout,
   output logic               valid,
   output logic               locked,
   output logic               err
);

   localparam logic [0:0] S_HUNT = 1'b0;
   localparam logic [0:0] S_SYNC = 1'b1;
   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   logic [0:0]         r_state;
   logic [BW-1:0]      r_bit_cnt;
   logic [1:0]         r_slot_cnt;
   logic [WIDTH-1:0]   r_sh [4];
   logic [4*WIDTH-1:0] r_dout;
   logic               r_valid;
   logic               r_err;
`ifdef TDM_DEMUX_LOSS_EN
   logic [1:0]         r_miss;
`endif

   logic               w_at_start;
   logic               w_last;
   logic [4*WIDTH-1:0] w_frame;

   assign w_at_start = (r_bit_cnt == '0) && (r_slot_cnt == 2'd0);
   assign w_last     = (r_bit_cnt == LAST_BIT) && (r_slot_cnt == 2'd3);
   // Channel 3 still lacks its final bit, which arrives on the completing strobe.
   assign w_frame    = {{r_sh[3][WIDTH-2:0], din}, r_sh[2], r_sh[1], r_sh[0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_HUNT;
         r_bit_cnt  <= '0;
         r_slot_cnt <= 2'd0;
         for (int k = 0; k < 4; k++) r_sh[k] <= '0;
         r_dout     <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
`ifdef TDM_DEMUX_LOSS_EN
         r_miss     <= 2'd0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (en) begin
            if (r_state == S_HUNT) begin
               if (fsync) begin
                  r_sh[0]    <= {r_sh[0][WIDTH-2:0], din};
                  r_bit_cnt  <= BW'(1);
                  r_slot_cnt <= 2'd0;
                  r_state    <= S_SYNC;
               end
            end else if (fsync && !w_at_start) begin
               // Misplaced marker: drop the partial frame and restart on this bit.
               r_err      <= 1'b1;
               r_sh[0]    <= {r_sh[0][WIDTH-2:0], din};
               r_bit_cnt  <= BW'(1);
               r_slot_cnt <= 2'd0;
            end
`ifdef TDM_DEMUX_LOSS_EN
            else if (!fsync && w_at_start && (r_miss != 2'd0)) begin
               r_err      <= 1'b1;
               r_state    <= S_HUNT;
               r_bit_cnt  <= '0;
               r_slot_cnt <= 2'd0;
               r_miss     <= 2'd0;
            end
`endif
            else begin
`ifdef TDM_DEMUX_LOSS_EN
               if (w_at_start) r_miss <= fsync ? 2'd0 : r_miss + 2'd1;
`endif
               r_sh[r_slot_cnt] <= {r_sh[r_slot_cnt][WIDTH-2:0], din};
               if (r_bit_cnt == LAST_BIT) begin
                  r_bit_cnt  <= '0;
                  r_slot_cnt <= r_slot_cnt + 2'd1;
               end else begin
                  r_bit_cnt  <= r_bit_cnt + BW'(1);
               end
               if (w_last) begin
                  r_dout  <= w_frame;
                  r_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign dout   = r_dout;
   assign valid  = r_valid;
   assign err    = r_err;
   assign locked = (r_state == S_SYNC);

endmodule

// File: tb/tb_tdm_demux_4.sv
// Bench for tdm_demux_4: table of frames plus hand-built sequences, with an expected-word queue.
module tb_tdm_demux_4;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst, en, din, fsync;
   logic [4*W-1:0] dout;
   logic          valid, locked, err;

   tdm_demux_4 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .fsync(fsync),
      .dout(dout), .valid(valid), .locked(locked), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ch [4];
      int          gap;
      logic [31:0] exp;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          err_cnt = 0;
   logic        rst_q = 1'b1;
   logic [31:0] model_dout = '0;
   logic [31:0] exp_q [$];
   int          vtimes [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   always @(negedge clk) begin
      if (rst_q) begin
         model_dout = '0;
      end else begin
         if (err === 1'b1) err_cnt++;
         if (valid === 1'b1) begin
            vtimes.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_valid", {31'd0, valid}, 32'd0);
            end else begin
               model_dout = exp_q.pop_front();
               check("dout_on_valid", dout, model_dout);
            end
         end else begin
            check("dout_hold", dout, model_dout);
         end
      end
   end

   task automatic idle(input int n);
      en = 1'b0; fsync = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Sends nbits of word w (slot 0 first, MSB first); fsync rides on the first bit if fs.
   task automatic send(input logic [31:0] w, input int nbits, input int gap, input bit fs,
                       input bit push, input logic [31:0] expw, input bit exp_err,
                       input bit exp_lock, input string tag);
      for (int i = 0; i < nbits; i++) begin
         int slot;
         int b;
         slot  = i / W;
         b     = W - 1 - (i % W);
         en    = 1'b1;
         din   = w[slot*W + b];
         fsync = fs && (i == 0);
         if (push && i == nbits - 1) exp_q.push_back(expw);
         @(posedge clk); #1;
         if (i == 0) begin
            check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
            check({tag, "_locked"}, {31'd0, locked}, {31'd0, exp_lock});
         end
         for (int g = 0; g < gap; g++) begin
            en = 1'b0; din = 1'($urandom); fsync = 1'($urandom);
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [4];
      logic [31:0] w;
      int          e0;
      int          v0;

      tbl[0] = '{'{8'hA5, 8'h3C, 8'h0F, 8'hF0}, 0, 32'hF00F3CA5};
      tbl[1] = '{'{8'hA5, 8'h3C, 8'h0F, 8'hF0}, 2, 32'hF00F3CA5};
      tbl[2] = '{'{8'h11, 8'h22, 8'h33, 8'h44}, 0, 32'h44332211};
      tbl[3] = '{'{8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1, 32'hDEADBEEF};

      rst = 1'b1; en = 1'b0; din = 1'b0; fsync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout", dout, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 4; i++) begin
         w = {tbl[i].ch[3], tbl[i].ch[2], tbl[i].ch[1], tbl[i].ch[0]};
         send(w, 32, tbl[i].gap, 1'b1, 1'b1, tbl[i].exp, 1'b0, 1'b1, "tbl");
         idle(3);
         check("tbl_drained", exp_q.size(), 32'd0);
      end

      // Marker lands on slot 2, bit 3 of a partial frame.
      e0 = err_cnt;
      send(32'h99887766, 19, 0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, "part");
      send(32'h44332211, 32, 0, 1'b1, 1'b1, 32'h44332211, 1'b1, 1'b1, "mis");
      idle(3);
      check("mis_err_count", err_cnt - e0, 32'd1);
      check("mis_drained", exp_q.size(), 32'd0);

      // Back-to-back frames with no gap.
      e0 = err_cnt;
      vtimes.delete();
      send(32'h01020304, 32, 0, 1'b1, 1'b1, 32'h01020304, 1'b0, 1'b1, "b2b0");
      send(32'hCAFEF00D, 32, 0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, "b2b1");
      send(32'h5A5AA5A5, 32, 0, 1'b1, 1'b1, 32'h5A5AA5A5, 1'b0, 1'b1, "b2b2");
      idle(3);
      check("b2b_nvalid", vtimes.size(), 32'd3);
      if (vtimes.size() == 3) begin
         check("b2b_gap01", vtimes[1] - vtimes[0], 32'd32);
         check("b2b_gap12", vtimes[2] - vtimes[1], 32'd32);
      end
      check("b2b_err_count", err_cnt - e0, 32'd0);
      check("b2b_drained", exp_q.size(), 32'd0);

      // Lock, then two frames without a marker.
      send(32'h10203040, 32, 0, 1'b1, 1'b1, 32'h10203040, 1'b0, 1'b1, "sl1");
      send(32'h50607080, 32, 0, 1'b0, 1'b1, 32'h50607080, 1'b0, 1'b1, "sl2");
`ifdef TDM_DEMUX_LOSS_EN
      send(32'h90A0B0C0, 32, 0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, "sl3");
      idle(3);
      check("sl_locked", {31'd0, locked}, 32'd0);
`else
      send(32'h90A0B0C0, 32, 0, 1'b0, 1'b1, 32'h90A0B0C0, 1'b0, 1'b1, "sl3");
      idle(3);
      check("sl_locked", {31'd0, locked}, 32'd1);
`endif
      check("sl_drained", exp_q.size(), 32'd0);

      // Reset during slot 1, then 64 bits that never carry a marker.
      send(32'h0BADF00D, 12, 0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, "rm");
      en = 1'b0; fsync = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rm_dout", dout, 32'd0);
      check("rm_locked", {31'd0, locked}, 32'd0);
      v0 = vtimes.size();
      send(32'hFFFF0000, 32, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "ns1");
      send(32'h12345678, 32, 1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, "ns2");
      idle(3);
      check("ns_dout", dout, 32'd0);
      check("ns_locked", {31'd0, locked}, 32'd0);
      check("ns_nvalid", vtimes.size() - v0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
